cache_refill_ctrl: RTL

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl_pkg.sv | 28 ++
 rtl/cache_refill_ctrl_latency_timer.sv | 31 +++
 rtl/cache_refill_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and address-field geometry for the cache refill controller.
// Included by cache_refill_ctrl and latency_timer.
package cache_refill_ctrl_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 10;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 128;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int BLK_ADDR_W = TAG_W + INDEX_W;

    // Address layout: {tag, index, word offset}
    localparam int OFFSET_LSB = 0;
    localparam int OFFSET_MSB = OFFSET_W - 1;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int INDEX_MSB  = INDEX_LSB + INDEX_W - 1;
    localparam int TAG_LSB    = INDEX_MSB + 1;
    localparam int TAG_MSB    = ADDR_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FETCH,
        ST_FILL,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cache_refill_ctrl_latency_timer.sv
// Main-memory latency countdown: load arms it, done is high in the last
// counting cycle, so a counting window of exactly LATENCY cycles results.
module latency_timer
    import cache_refill_ctrl_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

    logic [3:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= LOAD_VAL;
        end else if (count && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    assign done = count && (cnt_reg == 4'd0);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Blocking cache refill controller: lookup, memory fetch, line fill, response.
// Hit/miss statistics counters exist only when REFILL_STATS_EN is defined.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  req_ready,
    output logic [ADDR_W-1:0]     cur_addr,
    input  logic                  hit,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [BLOCK_W-1:0]    mem_data,
    output logic                  fill_we,
    output logic [TAG_W-1:0]      fill_tag,
    output logic [INDEX_W-1:0]    fill_index,
    output logic [BLOCK_W-1:0]    fill_data,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    cur_addr_reg;
    logic [BLOCK_W-1:0]   fill_data_reg;
    logic                 hit_reg;
    logic                 timer_done;

    latency_timer #(.LATENCY(MEM_LATENCY)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_reg == ST_LOOKUP),
        .count (state_reg == ST_FETCH),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_valid) state_next = ST_LOOKUP;
            ST_LOOKUP: state_next = hit ? ST_RESP : ST_FETCH;
            ST_FETCH:  if (timer_done) state_next = ST_FILL;
            ST_FILL:   state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath registers hold until the next accept / capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_reg  <= '0;
            fill_data_reg <= '0;
            hit_reg       <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && req_valid) cur_addr_reg <= req_addr;
            if (state_reg == ST_LOOKUP) hit_reg <= hit;
            if ((state_reg == ST_FETCH) && timer_done) fill_data_reg <= mem_data;
        end
    end

    // req_ready is also gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        req_ready  = (state_reg == ST_IDLE) && rst_n;
        mem_rd     = (state_reg == ST_FETCH);
        mem_addr   = (state_reg == ST_FETCH) ? cur_addr_reg[TAG_MSB:INDEX_LSB] : '0;
        fill_we    = (state_reg == ST_FILL);
        resp_valid = (state_reg == ST_RESP);
        resp_hit   = (state_reg == ST_RESP) && hit_reg;
    end

    assign cur_addr   = cur_addr_reg;
    assign fill_tag   = cur_addr_reg[TAG_MSB:TAG_LSB];
    assign fill_index = cur_addr_reg[INDEX_MSB:INDEX_LSB];
    assign fill_data  = fill_data_reg;

`ifdef REFILL_STATS_EN
    logic [CNT_W-1:0] hit_count_reg, miss_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (state_reg == ST_LOOKUP) begin
            if (hit && (hit_count_reg != '1)) hit_count_reg <= hit_count_reg + 1'b1;
            if (!hit && (miss_count_reg != '1)) miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
